fir_output_stage: RTL and testbench

FIR_OUTPUT_STAGE -- requirements
Module: fir_output_stage

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_out_fifo.sv | 75 +++++++
 rtl/fir_output_stage.sv | 102 ++++++++++
 tb/tb_fir_output_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths for the FIR slice chain and its output stage.
package fir_pkg;

    localparam int SAMPLE_W = 4;
    localparam int COEFF_W  = 8;
    localparam int ACC_W    = 12;
    localparam int OUT_W    = 8;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] out_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Show-ahead output FIFO; occupancy count alone separates full from empty.
module fir_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic                      rd_en_i,
    output logic [WIDTH-1:0]          rd_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             isFull;
    logic             doPop;
    logic             doPush;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    always_comb begin
        isFull  = (count_q == DEPTH_C);
        doPop   = rd_en_i && (count_q != '0);
        doPush  = wr_en_i && (!isFull || doPop);
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = (count_q != '0) ? mem_q[rdPtr_q] : '0;
        count_o   = count_q;
        empty_o   = (count_q == '0);
        drop_o    = wr_en_i && isFull && !doPop;
    end

endmodule

// File: rtl/fir_output_stage.sv
// Output stage of the FIR chain: capture timing, round/saturate, and buffering.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int PIPE_LAT   = 8,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic signed [ACC_W-1:0]       accum_in,
    output logic signed [OUT_W-1:0]       dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          sat_flag,
    output logic                          overflow_flag
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] ROUND_C   = SUM_W'(1 << (SHIFT - 1));
    localparam logic signed [SUM_W-1:0] OUT_MAX_C = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN_C = SUM_W'(-(1 << (OUT_W - 1)));

    logic [PIPE_LAT-1:0]     validPipe_q, validPipe_d;
    logic                    capEn;
    logic signed [SUM_W-1:0] sumRounded;
    logic signed [SUM_W-1:0] shifted;
    logic signed [OUT_W-1:0] clamped;
    logic                    satHit;
    logic                    s1Valid_q, s1Valid_d;
    logic signed [OUT_W-1:0] s1Data_q, s1Data_d;
    logic                    sat_q, sat_d;
    logic                    ovf_q, ovf_d;
    logic                    popEn;
    logic                    fifoEmpty;
    logic                    fifoDrop;
    logic [OUT_W-1:0]        fifoData;

    // The valid pipe mirrors the slice chain latency, so its last tap is the
    // only cycle in which accum_in carries a real sum.
    always_comb begin
        validPipe_d = {validPipe_q[PIPE_LAT-2:0], sample_valid};
        capEn       = validPipe_q[PIPE_LAT-1];
        sumRounded  = $signed({accum_in[ACC_W-1], accum_in}) + ROUND_C;
        shifted     = sumRounded >>> SHIFT;
        clamped     = shifted[OUT_W-1:0];
        satHit      = 1'b0;
        if (shifted > OUT_MAX_C) begin
            clamped = OUT_MAX_C[OUT_W-1:0];
            satHit  = 1'b1;
        end else if (shifted < OUT_MIN_C) begin
            clamped = OUT_MIN_C[OUT_W-1:0];
            satHit  = 1'b1;
        end
        s1Valid_d = capEn;
        s1Data_d  = capEn ? clamped : s1Data_q;
        sat_d     = sat_q | (capEn & satHit);
        ovf_d     = ovf_q | fifoDrop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validPipe_q <= '0;
            s1Valid_q   <= 1'b0;
            s1Data_q    <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            validPipe_q <= validPipe_d;
            s1Valid_q   <= s1Valid_d;
            s1Data_q    <= s1Data_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
        end
    end

    fir_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (s1Valid_q),
        .wr_data_i (s1Data_q),
        .rd_en_i   (popEn),
        .rd_data_o (fifoData),
        .count_o   (fifo_count),
        .empty_o   (fifoEmpty),
        .drop_o    (fifoDrop)
    );

    always_comb begin
        dout_valid    = !fifoEmpty;
        popEn         = dout_valid && dout_ready;
        dout          = $signed(fifoData);
        sat_flag      = sat_q;
        overflow_flag = ovf_q;
    end

endmodule

// File: tb/tb_fir_output_stage.sv
// Cycle-driven bench for fir_output_stage with a queue scoreboard of expected FIFO contents.
module tb_fir_output_stage;
    import fir_pkg::*;

    localparam int PIPE_LAT   = 8;
    localparam int SHIFT      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int SCHED_N    = 64;
    localparam int DIV        = 1 << SHIFT;
    localparam int HALF       = DIV / 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    sample_valid = 1'b0;
    logic signed [ACC_W-1:0] accum_in = '0;
    logic                    dout_ready = 1'b0;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_valid;
    logic [CW-1:0]           fifo_count;
    logic                    sat_flag;
    logic                    overflow_flag;

    int total = 0;
    int bad = 0;
    int dutPops = 0;
    int base;

    int expQ[$];
    bit svHist[PIPE_LAT];
    bit mS1v;
    int mS1d;
    bit mSat;
    bit mOvf;

    bit sv_s[SCHED_N];
    int acc_s[SCHED_N];
    bit rdy_s[SCHED_N];

    always #5 clk = ~clk;

    fir_output_stage #(
        .PIPE_LAT   (PIPE_LAT),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .accum_in      (accum_in),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .fifo_count    (fifo_count),
        .sat_flag      (sat_flag),
        .overflow_flag (overflow_flag)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    // Round half up with floor semantics, computed with plain integer division.
    function automatic int expRound(input int acc);
        int t;
        t = acc + HALF;
        if (t >= 0) return t / DIV;
        return -((-t + DIV - 1) / DIV);
    endfunction

    task automatic clearModel();
        expQ.delete();
        foreach (svHist[i]) svHist[i] = 1'b0;
        mS1v = 1'b0;
        mS1d = 0;
        mSat = 1'b0;
        mOvf = 1'b0;
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the model.
    task automatic applyStimulus(input bit sv, input int acc, input bit rdy);
        bit pop, full, accept, cap;
        int r;
        sample_valid = sv;
        accum_in     = ACC_W'(acc);
        dout_ready   = rdy;
        @(negedge clk);
        checkOutput("dout_valid", dout_valid, expQ.size() != 0);
        checkOutput("fifo_count", fifo_count, expQ.size());
        checkOutput("dout", dout, (expQ.size() != 0) ? expQ[0] : 0);
        checkOutput("sat_flag", sat_flag, mSat);
        checkOutput("overflow_flag", overflow_flag, mOvf);
        if (dout_valid === 1'b1 && rdy) dutPops++;

        pop    = (expQ.size() != 0) && rdy;
        full   = (expQ.size() >= FIFO_DEPTH);
        accept = mS1v && (!full || pop);
        if (mS1v && !accept) mOvf = 1'b1;
        if (pop) void'(expQ.pop_front());
        if (accept) expQ.push_back(mS1d);

        cap = svHist[PIPE_LAT-1];
        if (cap) begin
            r = expRound(acc);
            if (r > 127) begin
                r = 127;
                mSat = 1'b1;
            end else if (r < -128) begin
                r = -128;
                mSat = 1'b1;
            end
            mS1d = r;
        end
        mS1v = cap;
        for (int i = PIPE_LAT - 1; i > 0; i--) svHist[i] = svHist[i-1];
        svHist[0] = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic clearSched(input bit rdy);
        for (int i = 0; i < SCHED_N; i++) begin
            sv_s[i]  = 1'b0;
            acc_s[i] = int'($urandom_range(4095)) - 2048;
            rdy_s[i] = rdy;
        end
    endtask

    task automatic runRange(input int lo, input int hi);
        for (int i = lo; i < hi; i++) applyStimulus(sv_s[i], acc_s[i], rdy_s[i]);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        sample_valid = 1'b0;
        dout_ready = 1'b0;
        clearModel();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clearModel();
        #1;
        checkOutput("rst_dout_valid", dout_valid, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_sat", sat_flag, 0);
        checkOutput("rst_ovf", overflow_flag, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single pulse: only the cycle-8 accumulator value may be captured.
        clearSched(1'b1);
        sv_s[0]  = 1'b1;
        acc_s[7] = 2047;
        acc_s[8] = 100;
        acc_s[9] = -2048;
        base = dutPops;
        runRange(0, 14);
        checkOutput("single_outs", dutPops - base, 1);

        // Rounding and saturation corners.
        clearSched(1'b1);
        for (int i = 0; i < 5; i++) sv_s[i] = 1'b1;
        acc_s[8]  = -2048;
        acc_s[9]  = -24;
        acc_s[10] = 8;
        acc_s[11] = 7;
        acc_s[12] = 2047;
        runRange(0, 11);
        checkOutput("sat_after_neg", sat_flag, 0);
        runRange(11, 18);
        checkOutput("sat_after_pos", sat_flag, 1);

        // Backpressure with one more capture than the FIFO holds.
        clearSched(1'b0);
        for (int i = 0; i < 5; i++) begin
            sv_s[i]    = 1'b1;
            acc_s[8+i] = 16 * (i + 1);
        end
        runRange(0, 16);
        checkOutput("bp_count", fifo_count, 4);
        checkOutput("bp_ovf", overflow_flag, 1);
        clearSched(1'b1);
        base = dutPops;
        runRange(0, 6);
        checkOutput("bp_drained_outs", dutPops - base, 4);
        checkOutput("bp_drained_valid", dout_valid, 0);

        // Full FIFO with a pop in the same cycle as the fifth write.
        resetDut();
        clearSched(1'b0);
        for (int i = 0; i < 5; i++) begin
            sv_s[i]    = 1'b1;
            acc_s[8+i] = 16 * (i + 2);
        end
        rdy_s[13] = 1'b1;
        base = dutPops;
        runRange(0, 16);
        checkOutput("fullpop_count", fifo_count, 4);
        checkOutput("fullpop_ovf", overflow_flag, 0);
        clearSched(1'b1);
        runRange(0, 6);
        checkOutput("fullpop_outs", dutPops - base, 5);

        // Mid-cycle reset with three queued and two in flight.
        resetDut();
        clearSched(1'b0);
        for (int i = 0; i < 5; i++) begin
            sv_s[i]    = 1'b1;
            acc_s[8+i] = 16 * (i + 1);
        end
        acc_s[8] = 2047;
        runRange(0, 12);
        checkOutput("pre_rst_count", fifo_count, 3);
        checkOutput("pre_rst_sat", sat_flag, 1);
        sample_valid = 1'b0;
        dout_ready   = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_dout_valid", dout_valid, 0);
        checkOutput("midrst_dout", dout, 0);
        checkOutput("midrst_count", fifo_count, 0);
        checkOutput("midrst_sat", sat_flag, 0);
        checkOutput("midrst_ovf", overflow_flag, 0);
        clearModel();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearSched(1'b1);
        base = dutPops;
        runRange(0, 20);
        checkOutput("post_rst_outs", dutPops - base, 0);

        // Continuous stream at one result per cycle.
        clearSched(1'b1);
        for (int i = 0; i < 20; i++) sv_s[i] = 1'b1;
        base = dutPops;
        runRange(0, 32);
        checkOutput("stream_outs", dutPops - base, 20);
        checkOutput("stream_ovf", overflow_flag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
